// File: rtl/alu6_arbiter_if.sv
// Request/response/ALU-side bundle for alu6_arbiter.
// slave = arbiter side, master = requesters, consumer and ALU side.
interface alu6_arbiter_if #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned OPW   = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req0_cin;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;
    logic             req1_cin;
    logic             req1_ready;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic             resp_cout;
    logic             resp_err;
    logic             busy;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op, req1_cin,
        output req1_ready,
        output resp_valid, resp_id, resp_result, resp_cout, resp_err, busy,
        input  resp_ready,
        output alu_a, alu_b, alu_op, alu_cin,
        input  alu_result, alu_cout
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op, req1_cin,
        input  req1_ready,
        input  resp_valid, resp_id, resp_result, resp_cout, resp_err, busy,
        output resp_ready,
        input  alu_a, alu_b, alu_op, alu_cin,
        output alu_result, alu_cout
    );
endinterface

// File: rtl/alu6_arbiter.sv
// Two-requester round-robin front end for a shared combinational 6-bit ALU.
// Optional opcode filtering is enabled by defining ALU_OP_CHECK_EN.
module alu6_arbiter #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned OPW   = 4
) (
    input logic           clk,
    input logic           reset,
    alu6_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             alu_cin_q, alu_cin_d;
    logic             vld_q, vld_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;

    logic             gnt0_c, gnt1_c, legal_c;
    logic [WIDTH-1:0] sel_a_c, sel_b_c;
    logic [OPW-1:0]   sel_op_c;
    logic             sel_cin_c;

    // Grant: lone requester wins, rr_q breaks ties; nothing granted while in reset
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (reset && (state_q == IDLE)) begin
            if (bus.req0_valid && (!bus.req1_valid || !rr_q)) begin
                gnt0_c = 1'b1;
            end else if (bus.req1_valid) begin
                gnt1_c = 1'b1;
            end
        end
    end

    // Payload of the granted requester
    always_comb begin
        sel_a_c   = gnt1_c ? bus.req1_a   : bus.req0_a;
        sel_b_c   = gnt1_c ? bus.req1_b   : bus.req0_b;
        sel_op_c  = gnt1_c ? bus.req1_op  : bus.req0_op;
        sel_cin_c = gnt1_c ? bus.req1_cin : bus.req0_cin;
`ifdef ALU_OP_CHECK_EN
        legal_c   = sel_op_c inside {OPW'(0), OPW'(1), OPW'(2), OPW'(6), OPW'(7), OPW'(12)};
`else
        legal_c   = 1'b1;
`endif
    end

    // Next state and next register values
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        alu_cin_d = alu_cin_q;
        vld_d     = vld_q;
        id_d      = id_q;
        res_d     = res_q;
        cout_d    = cout_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (gnt0_c || gnt1_c) begin
                    id_d = gnt1_c;
                    rr_d = gnt0_c;
                    if (legal_c) begin
                        alu_a_d   = sel_a_c;
                        alu_b_d   = sel_b_c;
                        alu_op_d  = sel_op_c;
                        alu_cin_d = sel_cin_c;
                        err_d     = 1'b0;
                        state_d   = EXEC;
                    end else begin
                        // Rejected opcode: answer immediately, ALU inputs untouched
                        err_d   = 1'b1;
                        res_d   = '0;
                        cout_d  = 1'b0;
                        vld_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                res_d   = bus.alu_result;
                cout_d  = bus.alu_cout;
                vld_d   = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                vld_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            alu_cin_q <= 1'b0;
            vld_q     <= 1'b0;
            id_q      <= 1'b0;
            res_q     <= '0;
            cout_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            alu_cin_q <= alu_cin_d;
            vld_q     <= vld_d;
            id_q      <= id_d;
            res_q     <= res_d;
            cout_q    <= cout_d;
            err_q     <= err_d;
        end
    end

    assign bus.req0_ready  = gnt0_c;
    assign bus.req1_ready  = gnt1_c;
    assign bus.busy        = (state_q != IDLE);
    assign bus.resp_valid  = vld_q;
    assign bus.resp_id     = id_q;
    assign bus.resp_result = res_q;
    assign bus.resp_cout   = cout_q;
    assign bus.resp_err    = err_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_cin     = alu_cin_q;

endmodule

// File: tb/tb_alu6_arbiter.sv
// Self-checking bench for alu6_arbiter: directed plan steps plus randomized
// traffic against a transaction-level model; includes a behavioural ALU.
module tb_alu6_arbiter;
    localparam int unsigned WIDTH = 6;
    localparam int unsigned OPW   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu6_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus();
    alu6_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    int favour = 0;                 // requester that wins the next tie
    logic [WIDTH-1:0] m_a   = '0;   // what the ALU input registers should hold
    logic [WIDTH-1:0] m_b   = '0;
    logic [OPW-1:0]   m_op  = '0;
    logic             m_cin = 1'b0;

    // Behavioural ALU: returns {carry, result}
    function automatic logic [WIDTH:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [OPW-1:0] op, input logic cin);
        int ia, ib, sum, sa, sb;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 32) ? ia - 64 : ia;
        sb = (ib >= 32) ? ib - 64 : ib;
        case (int'(op))
            0:       return {1'b0, a & b};
            1:       return {1'b0, a | b};
            2:       begin sum = ia + ib + int'(cin);        return (WIDTH+1)'(sum); end
            6:       begin sum = ia + (63 - ib) + int'(cin); return (WIDTH+1)'(sum); end
            7:       return (sa < sb) ? 7'd1 : 7'd0;
            12:      return {1'b0, ~(a | b)};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    function automatic bit op_legal(input logic [OPW-1:0] op);
`ifdef ALU_OP_CHECK_EN
        int o;
        o = int'(op);
        return (o == 0) || (o == 1) || (o == 2) || (o == 6) || (o == 7) || (o == 12);
`else
        return (op === op);
`endif
    endfunction

    always_comb {bus.alu_cout, bus.alu_result} = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete transaction; the losing requester stays valid throughout
    task automatic do_txn(input bit v0, input logic [5:0] a0, input logic [5:0] b0,
                          input logic [3:0] op0, input logic cin0,
                          input bit v1, input logic [5:0] a1, input logic [5:0] b1,
                          input logic [3:0] op1, input logic cin1, input int stall);
        int g;
        logic [5:0] ea, eb;
        logic [3:0] eop;
        logic ecin;
        logic [6:0] er;
        bit legal;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0; bus.req0_cin = cin0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1; bus.req1_cin = cin1;
        bus.resp_ready = (stall == 0);
        #1;
        g = (v0 && v1) ? favour : (v0 ? 0 : 1);
        if (g == 0) begin ea = a0; eb = b0; eop = op0; ecin = cin0; end
        else        begin ea = a1; eb = b1; eop = op1; ecin = cin1; end
        legal = op_legal(eop);
        check("grant_ready0", 32'(bus.req0_ready), 32'(g == 0));
        check("grant_ready1", 32'(bus.req1_ready), 32'(g == 1));
        tick;
        favour = 1 - g;
        if (g == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
        if (legal) begin
            m_a = ea; m_b = eb; m_op = eop; m_cin = ecin;
            er = alu_ref(ea, eb, eop, ecin);
            check("exec_busy", 32'(bus.busy), 32'd1);
            check("exec_resp_valid", 32'(bus.resp_valid), 32'd0);
            check("exec_alu_a", 32'(bus.alu_a), 32'(ea));
            tick;
        end else begin
            er = '0;
        end
        for (int s = 0; s <= stall; s++) begin
            if (s == stall) bus.resp_ready = 1'b1;
            check("resp_valid", 32'(bus.resp_valid), 32'd1);
            check("resp_id", 32'(bus.resp_id), 32'(g));
            check("resp_result", 32'(bus.resp_result), 32'(er[5:0]));
            check("resp_cout", 32'(bus.resp_cout), 32'(er[6]));
            check("resp_err", 32'(bus.resp_err), 32'(!legal));
            check("resp_alu_op", 32'(bus.alu_op), 32'(m_op));
            check("resp_alu_b", 32'(bus.alu_b), 32'(m_b));
            check("resp_busy", 32'(bus.busy), 32'd1);
            check("resp_no_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            tick;
        end
        bus.resp_ready = 1'b0;
        check("done_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("done_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [3:0] legal_ops [6];
        logic [5:0] ra0, rb0, ra1, rb1;
        logic [3:0] rop0, rop1;
        int vsel;
        legal_ops[0] = 4'd0; legal_ops[1] = 4'd1; legal_ops[2] = 4'd2;
        legal_ops[3] = 4'd6; legal_ops[4] = 4'd7; legal_ops[5] = 4'd12;

        // Reset with both requesters valid: no grant while held low
        reset = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0; bus.req1_cin = 1'b0;
        bus.resp_ready = 1'b0;
        tick;
        tick;
        check("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        check("rst_resp", 32'({bus.resp_valid, bus.resp_id, bus.resp_cout, bus.resp_err, bus.busy}), 32'd0);
        check("rst_result", 32'(bus.resp_result), 32'd0);
        check("rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin}), 32'd0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        reset = 1'b1;
        tick;
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Directed plan steps
        do_txn(1, 6'd5, 6'd2, 4'd6, 1'b1, 0, 6'd0, 6'd0, 4'd0, 1'b0, 0);
        check("plan_sub_result", 32'(bus.resp_result), 32'd3);
        check("plan_sub_cout", 32'(bus.resp_cout), 32'd1);
        do_txn(0, 6'd0, 6'd0, 4'd0, 1'b0, 1, 6'd5, 6'd2, 4'd2, 1'b0, 0);
        check("plan_add_result", 32'(bus.resp_result), 32'd7);
        do_txn(0, 6'd0, 6'd0, 4'd0, 1'b0, 1, 6'd5, 6'd2, 4'd1, 1'b0, 1);
        check("plan_or_result", 32'(bus.resp_result), 32'd7);
        check("plan_or_id", 32'(bus.resp_id), 32'd1);
        do_txn(0, 6'd0, 6'd0, 4'd0, 1'b0, 1, 6'd63, 6'd1, 4'd2, 1'b0, 0);
        check("plan_wrap_result", 32'(bus.resp_result), 32'd0);
        check("plan_wrap_cout", 32'(bus.resp_cout), 32'd1);

        // Backpressure for 5 cycles with the other requester waiting
        do_txn(1, 6'd9, 6'd4, 4'd0, 1'b0, 1, 6'd3, 6'd3, 4'd12, 1'b0, 5);

        // Opcode 4: rejected or forwarded depending on the build
        do_txn(1, 6'd12, 6'd10, 4'd4, 1'b0, 0, 6'd0, 6'd0, 4'd0, 1'b0, 0);
`ifdef ALU_OP_CHECK_EN
        check("op4_err", 32'(bus.resp_err), 32'd1);
`else
        check("op4_fwd_result", 32'(bus.resp_result), 32'd6);
        check("op4_fwd_op", 32'(bus.alu_op), 32'd4);
`endif

        // Reset during EXEC: transaction dropped, pointer back to requester 0
        bus.req0_valid = 1'b1; bus.req0_a = 6'd7; bus.req0_b = 6'd1; bus.req0_op = 4'd2; bus.req0_cin = 1'b1;
        #1;
        check("mid_grant", 32'(bus.req0_ready), 32'd1);
        tick;
        bus.req0_valid = 1'b0;
        check("mid_exec", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        favour = 0; m_a = '0; m_b = '0; m_op = '0; m_cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("mid_no_resp", 32'({bus.resp_valid, bus.busy}), 32'd0);
            check("mid_outputs", 32'({bus.resp_id, bus.resp_result, bus.resp_cout, bus.resp_err}), 32'd0);
            check("mid_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin}), 32'd0);
            tick;
        end

        // Both continuously valid: alternation starting from requester 0
        for (int i = 0; i < 6; i++) begin
            do_txn(1, 6'(i), 6'(i + 20), legal_ops[i], 1'(i), 1, 6'(i + 40), 6'(i + 3), legal_ops[5 - i], 1'b1, 0);
            check("alt_order", 32'(bus.resp_id), 32'(i % 2));
        end

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            vsel = $urandom_range(1, 3);
            ra0 = 6'($urandom); rb0 = 6'($urandom); ra1 = 6'($urandom); rb1 = 6'($urandom);
            rop0 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 5)];
            rop1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 5)];
            do_txn(vsel[0], ra0, rb0, rop0, 1'($urandom), vsel[1], ra1, rb1, rop1, 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu6_arbiter.md
Name: alu6_arbiter

Overview:
- Shares one combinational 6-bit ALU (a, b, ALUOp, CarryIn -> Result, CarryOut) between two requesters.
- Round-robin arbitration, valid/ready request handshake, registered response with backpressure.
- Sits directly in front of the existing ALU: drives its operand/opcode inputs from internal registers and captures Result/CarryOut.

Parameters:
- WIDTH, 6, operand/result width; must match the ALU.
- OPW, 4, ALUOp width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_a  input  WIDTH  requester 0 operand a
- req0_b  input  WIDTH  requester 0 operand b
- req0_op  input  OPW  requester 0 ALUOp
- req0_cin  input  1  requester 0 CarryIn
- req0_ready  output  1  requester 0 accepted this cycle
- req1_valid, req1_a, req1_b, req1_op, req1_cin, req1_ready  same as requester 0, for requester 1
- resp_valid  output  1  response available
- resp_ready  input  1  consumer accepts response
- resp_id  output  1  requester that owns the response
- resp_result  output  WIDTH  captured ALU Result
- resp_cout  output  1  captured ALU CarryOut
- resp_err  output  1  opcode rejected (see Optional Feature)
- busy  output  1  state != IDLE
- alu_a, alu_b  output  WIDTH  to ALU a, b
- alu_op  output  OPW  to ALU ALUOp
- alu_cin  output  1  to ALU CarryIn
- alu_result  input  WIDTH  from ALU Result
- alu_cout  input  1  from ALU CarryOut

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset (reset==0 at posedge):
  - state=IDLE, rr pointer=0 (requester 0 favoured).
  - All registered outputs cleared: alu_a/alu_b/alu_op/alu_cin, resp_valid, resp_id, resp_result, resp_cout, resp_err all 0.
  - busy=0; req*_ready=0.
- IDLE:
  - reqN_ready is combinational: asserted only in IDLE, for exactly one requester, the grant.
  - Grant rule: if only one valid, grant it; if both valid, grant the one the rr pointer selects.
  - On grant (valid&ready):
    - Latch the granted a/b/op/cin into alu_* registers and the requester index into resp_id.
    - Set rr pointer = other requester.
    - Next state EXEC.
  - No valid: stay IDLE; alu_* registers hold previous values.
- EXEC (one cycle): ALU inputs stable; at the clock edge capture alu_result into resp_result and alu_cout into resp_cout, set resp_valid=1, next state RESP.
- RESP:
  - resp_valid=1; all resp_* and alu_* outputs held stable.
  - resp_ready=1: clear resp_valid, next state IDLE.
  - Otherwise hold indefinitely.
- Timing:
  - Latency: request accepted at edge T -> resp_valid high after edge T+2.
  - Minimum issue interval 3 cycles. No ready in EXEC/RESP; requesters hold valid and payload until ready.
- Width rules: no arithmetic performed here; result and carry are the ALU's, truncated to WIDTH by the ALU.
- Starvation-free: with both requesters continuously valid, grants alternate 0,1,0,1.
- Reset mid-operation (EXEC or RESP): transaction dropped, no response produced, return to IDLE with reset values.
- A requester dropping valid before its grant is not an error; nothing is recorded.

Optional Feature:
- Macro: ALU_OP_CHECK_EN.
- Defined:
  - Legal ALUOp set: 0 (AND), 1 (OR), 2 (ADD), 6 (SUB), 7 (SLT), 12 (NOR).
  - A granted request with any other op still completes the handshake and advances the rr pointer, but goes IDLE -> RESP directly with resp_err=1, resp_result=0, resp_cout=0.
  - alu_* registers are not updated for the rejected request.
  - Legal requests: resp_err=0.
- Undefined: all ops forwarded to the ALU unchanged; resp_err tied 0.

Test Plan:
- Reset release, req0 a=5 b=2 op=6 cin=1, resp_ready=1 -> req0_ready same cycle; resp_valid two edges later with resp_id=0, resp_result=3, resp_cout=1.
- req1 a=5 b=2 op=2 cin=0, then op=1 -> resp_result=7 (id=1) both times; a=63 b=1 op=2 cin=0 -> resp_result=0, resp_cout=1.
- Both valid continuously, six requests total -> grant order 0,1,0,1,0,1; each response resp_id matches its grant.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_* held stable, busy=1, no ready to either requester; resp_ready=1 -> IDLE next cycle.
- reset pulled low during EXEC -> no resp_valid afterwards; all outputs 0; next request granted to requester 0.
- With ALU_OP_CHECK_EN: op=4 -> resp_err=1, resp_result=0 one edge after grant, alu_op unchanged. Without the macro: op=4 is forwarded and resp_err=0.
